// File: rtl/scan_sisr_analyzer_pkg.sv
// Shared constants and FSM encoding for the scan BIST response path.
// The scan_in generator uses the same polynomial constants.
package scan_sisr_analyzer_pkg;

  localparam int unsigned SISR_WIDTH = 26;
  localparam logic [SISR_WIDTH-1:0] SISR_TAPS = 26'h47;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/scan_sisr_analyzer_sisr.sv
// Serial-input signature register: seed load, shift enable and tap feedback.
module sisr_core #(
  parameter int unsigned WIDTH = 26,
  parameter logic [WIDTH-1:0] TAPS = 26'h47,
  parameter logic [WIDTH-1:0] SEED = '0
) (
  input  logic             clock,
  input  logic             reset_internal,
  input  logic             load,
  input  logic             enable,
  input  logic             serial_in,
  output logic [WIDTH-1:0] sig
);

  logic fb;

  assign fb = serial_in ^ (^(sig & TAPS));

  always_ff @(posedge clock) begin
    if (reset_internal || load) begin
      sig <= SEED;
    end else if (enable) begin
      sig <= {fb, sig[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/scan_sisr_analyzer.sv
// Compacts the scan_out stream into a SISR over N_BITS accepted shifts,
// then compares against GOLDEN and reports done/pass.
module scan_sisr_analyzer
  import scan_sisr_analyzer_pkg::*;
#(
  parameter int unsigned      WIDTH  = SISR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS   = SISR_TAPS,
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter int unsigned      N_BITS = 1024,
  parameter logic [WIDTH-1:0] GOLDEN = '0,
  parameter int unsigned      CNT_W  = 11
) (
  input  logic             clock,
  input  logic             reset_internal,
  input  logic             start,
  input  logic             control_state,
  input  logic             scan_out,
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  state_t state, next_state;
  logic [CNT_W-1:0] cnt;
  logic shift_en, load, last_shift;
  logic busy_nxt, done_nxt, pass_nxt;

  assign shift_en   = (state == COMPACT) && control_state;
  assign load       = start && ((state == IDLE) || (state == DONE));
  assign last_shift = shift_en && (cnt == CNT_W'(N_BITS - 1));

  sisr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_sisr (
    .clock          (clock),
    .reset_internal (reset_internal),
    .load           (load),
    .enable         (shift_en),
    .serial_in      (scan_out),
    .sig            (signature)
  );

  always_ff @(posedge clock) begin
    if (reset_internal) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = COMPACT;
      COMPACT: if (last_shift) next_state = COMPARE;
      COMPARE: next_state = DONE;
      DONE:    if (start) next_state = COMPACT;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_internal || load) begin
      cnt <= '0;
    end else if (shift_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flags are registered from next_state so they line up with the state register.
  always_comb begin
    busy_nxt = (next_state == COMPACT) || (next_state == COMPARE);
    done_nxt = (next_state == DONE);
    pass_nxt = pass;
    if (load) begin
      pass_nxt = 1'b0;
    end else if (state == COMPARE) begin
      pass_nxt = (signature == GOLDEN);
    end
  end

  always_ff @(posedge clock) begin
    if (reset_internal) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      pass <= pass_nxt;
    end
  end

endmodule

// File: tb/tb_scan_sisr_analyzer.sv
// Randomized self-checking bench for scan_sisr_analyzer with an in-bench session model.
module tb_scan_sisr_analyzer;

  logic clock = 1'b0;
  logic reset_internal = 1'b1;
  logic start = 1'b0;
  logic control_state = 1'b0;
  logic scan_out = 1'b0;

  logic [25:0] sig_o [3];
  logic        busy_o [3];
  logic        done_o [3];
  logic        pass_o [3];

  int unsigned tests = 0;
  int unsigned fails = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  scan_sisr_analyzer #(.N_BITS(20), .SEED(26'h0), .GOLDEN(26'h0), .CNT_W(11)) dut_a (
    .clock(clock), .reset_internal(reset_internal), .start(start),
    .control_state(control_state), .scan_out(scan_out),
    .signature(sig_o[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]));

  scan_sisr_analyzer #(.N_BITS(20), .SEED(26'h0), .GOLDEN(26'h40), .CNT_W(11)) dut_b (
    .clock(clock), .reset_internal(reset_internal), .start(start),
    .control_state(control_state), .scan_out(scan_out),
    .signature(sig_o[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]));

  scan_sisr_analyzer #(.N_BITS(1024), .SEED(26'h0), .GOLDEN(26'h0), .CNT_W(11)) dut_c (
    .clock(clock), .reset_internal(reset_internal), .start(start),
    .control_state(control_state), .scan_out(scan_out),
    .signature(sig_o[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]));

  // Session model: bits accepted since start, compare pending, done/pass flags.
  int unsigned mn [3] = '{20, 20, 1024};
  logic [25:0] mg [3] = '{26'h0, 26'h40, 26'h0};
  logic [25:0] m_sig [3];
  int unsigned m_cnt [3];
  bit m_sess [3], m_pend [3], m_done [3], m_pass [3];

  function automatic logic [25:0] compact(input logic [25:0] s, input logic b);
    int unsigned p;
    logic [25:0] top;
    p = $countones(s & 26'h47) % 2;
    top = '0;
    top[25] = b ^ p[0];
    return (s >> 1) | top;
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset_internal) begin
        m_sig[i] <= '0; m_cnt[i] <= 0;
        m_sess[i] <= 0; m_pend[i] <= 0; m_done[i] <= 0; m_pass[i] <= 0;
      end else if (m_pend[i]) begin
        m_pend[i] <= 0;
        m_done[i] <= 1;
        m_pass[i] <= (m_sig[i] == mg[i]);
      end else if (m_sess[i]) begin
        if (control_state) begin
          m_sig[i] <= compact(m_sig[i], scan_out);
          m_cnt[i] <= m_cnt[i] + 1;
          if (m_cnt[i] + 1 == mn[i]) begin
            m_sess[i] <= 0;
            m_pend[i] <= 1;
          end
        end
      end else if (start) begin
        m_sig[i] <= '0; m_cnt[i] <= 0;
        m_sess[i] <= 1; m_done[i] <= 0; m_pass[i] <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("sig[%0d]", i), 32'(sig_o[i]), 32'(m_sig[i]));
        chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(m_sess[i] || m_pend[i]));
        chk($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(m_done[i]));
        chk($sformatf("pass[%0d]", i), 32'(pass_o[i]), 32'(m_pass[i]));
        chk($sformatf("busy_done_excl[%0d]", i), 32'(busy_o[i] && done_o[i]), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic st, input logic cs, input logic so);
    start = st; control_state = cs; scan_out = so;
    tick();
    start = 1'b0; control_state = 1'b0; scan_out = 1'b0;
  endtask

  task automatic do_reset();
    reset_internal = 1'b1;
    tick();
    reset_internal = 1'b0;
  endtask

  // Start, then the single-one pattern over 20 accepted shifts, then the compare edge.
  task automatic one_hot_session();
    drive(1, 0, 0);
    for (int k = 0; k < 20; k++) drive(0, 1, (k == 0));
    drive(0, 0, 0);
  endtask

  initial begin
    start = 0; control_state = 0; scan_out = 0;
    reset_internal = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    reset_internal = 1'b0;
    chk("reset_sig", 32'(sig_o[0]), 32'h0);
    chk("reset_busy", 32'(busy_o[0]), 32'd0);
    chk("reset_done", 32'(done_o[0]), 32'd0);

    // 1: all-zero stream
    drive(1, 0, 0);
    for (int k = 0; k < 20; k++) drive(0, 1, 0);
    chk("t1_done_not_yet", 32'(done_o[0]), 32'd0);
    chk("t1_busy_compare", 32'(busy_o[0]), 32'd1);
    drive(0, 0, 0);
    chk("t1_done", 32'(done_o[0]), 32'd1);
    chk("t1_pass_g0", 32'(pass_o[0]), 32'd1);
    chk("t1_sig", 32'(sig_o[0]), 32'h0);

    // 2: single leading one
    one_hot_session();
    chk("t2_sig", 32'(sig_o[0]), 32'h40);
    chk("t2_model_sig", 32'(m_sig[0]), 32'h40);
    chk("t2_pass_g0", 32'(pass_o[0]), 32'd0);
    chk("t2_pass_g40", 32'(pass_o[1]), 32'd1);

    // 3: shift enable toggling, ignored bits randomized
    drive(1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) drive(0, 1, (i == 0));
      else drive(0, 0, 1'($urandom_range(1)));
      if (i == 37) chk("t3_done_early", 32'(done_o[0]), 32'd0);
    end
    chk("t3_done", 32'(done_o[1]), 32'd1);
    chk("t3_sig", 32'(sig_o[1]), 32'h40);

    // 4: reset mid-session
    drive(1, 0, 0);
    for (int k = 0; k < 10; k++) drive(0, 1, 1'($urandom_range(1)));
    do_reset();
    chk("t4_busy", 32'(busy_o[0]), 32'd0);
    chk("t4_sig", 32'(sig_o[0]), 32'h0);
    chk("t4_done", 32'(done_o[0]), 32'd0);
    one_hot_session();
    chk("t4_after_sig", 32'(sig_o[0]), 32'h40);

    // 5: start during COMPACT is ignored; start in DONE restarts
    drive(1, 0, 0);
    for (int k = 0; k < 20; k++) drive((k == 7), 1, (k == 0));
    drive(0, 0, 0);
    chk("t5_sig", 32'(sig_o[1]), 32'h40);
    chk("t5_pass_g40", 32'(pass_o[1]), 32'd1);
    drive(1, 0, 0);
    chk("t5_restart_done", 32'(done_o[1]), 32'd0);
    chk("t5_restart_pass", 32'(pass_o[1]), 32'd0);
    for (int k = 0; k < 20; k++) drive(0, 1, 1'($urandom_range(1)));
    drive(0, 0, 0);
    chk("t5_done_again", 32'(done_o[0]), 32'd1);

    // 6: long random session on the 1024-bit instance
    do_reset();
    drive(1, 0, 0);
    begin
      int unsigned acc = 0;
      int unsigned cyc = 0;
      while (acc < 1024 && cyc < 4000) begin
        logic cs;
        cs = ($urandom_range(3) != 0);
        if (cs) acc++;
        drive(0, cs, 1'($urandom_range(1)));
        cyc++;
      end
      cyc = 0;
      while (!done_o[2] && cyc < 10) begin
        drive(0, 0, 0);
        cyc++;
      end
      chk("t6_done_bound", 32'(done_o[2]), 32'd1);
    end
    for (int k = 0; k < 3; k++) drive(0, 1, 1'($urandom_range(1)));
    chk("t6_hold_in_done", 32'(done_o[2]), 32'd1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
